fmap_stream_reader: RTL

Reads the flattened multi-channel feature map produced by the multi-filter convolution layer and streams it out one element per handshake. It sits on the consumer side of the wide `outputConv` bus and converts it into a narrow valid/ready stream for pooling, buffering or off-chip transfer. It captures a snapshot on `start`, then emits elements in channel-major raster order with coordinate and framing sideband. An optional ReLU clamps negative elements to zero.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/fmap_index_counter.sv | 74 +++++++
 rtl/fmap_stream_reader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: default element width,
// a minimum-1-bit clog2 helper for index widths, and the streaming FSM encoding.
package cnn_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fsm_state_t;

  // Index width for a range of n values; never narrower than one bit
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_index_counter.sv
// Nested column/row/channel counter for channel-major raster traversal.
// Ports:
//   clk, reset    clock, async active-high reset
//   i_clear       synchronous return of all indices to 0
//   i_advance     step to the next element (column fastest, channel slowest)
//   o_channel/o_row/o_col   current indices
//   o_last_ch_c   current element is the last of its channel
//   o_last_c      current element is the last of the frame
module fmap_index_counter
  import cnn_pkg::*;
#(
  parameter int unsigned K  = 6,
  parameter int unsigned OH = 28,
  parameter int unsigned OW = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_advance,
  output logic [clog2(K)-1:0]   o_channel,
  output logic [clog2(OH)-1:0]  o_row,
  output logic [clog2(OW)-1:0]  o_col,
  output logic                  o_last_ch_c,
  output logic                  o_last_c
);

  localparam int unsigned CW = clog2(K);
  localparam int unsigned RW = clog2(OH);
  localparam int unsigned XW = clog2(OW);

  logic [CW-1:0] r_channel;
  logic [RW-1:0] r_row;
  logic [XW-1:0] r_col;
  logic          w_col_wrap;
  logic          w_row_wrap;
  logic          w_ch_wrap;

  // A dimension of size 1 always reports wrap, so its counter stays at 0
  assign w_col_wrap = (r_col     == XW'(OW - 1));
  assign w_row_wrap = (r_row     == RW'(OH - 1));
  assign w_ch_wrap  = (r_channel == CW'(K - 1));

  // Column steps every advance; row and channel carry on wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_channel <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else if (i_clear) begin
      r_channel <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else if (i_advance) begin
      if (w_col_wrap) begin
        r_col <= '0;
        if (w_row_wrap) begin
          r_row     <= '0;
          r_channel <= w_ch_wrap ? '0 : r_channel + CW'(1);
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + XW'(1);
      end
    end
  end

  assign o_channel   = r_channel;
  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_last_ch_c = w_col_wrap & w_row_wrap;
  assign o_last_c    = w_col_wrap & w_row_wrap & w_ch_wrap;

endmodule

// File: rtl/fmap_stream_reader.sv
// Snapshots a flattened K x OH x OW feature map on start and streams it out
// one element per valid/ready handshake in channel-major raster order, with
// coordinate and framing sideband and optional ReLU.
// Ports:
//   clk, reset      clock, async active-high reset
//   start           capture fmap and begin a frame (ignored while streaming)
//   fmap            packed map, element e at bits [e*DATA_WIDTH +: DATA_WIDTH]
//   busy            frame in progress
//   out_valid/out_ready   output handshake
//   out_data        current element (ReLU applied when RELU=1)
//   out_channel/out_row/out_col   element coordinates
//   out_last_ch/out_last  last element of channel / of frame
//   done            one-cycle pulse after the final handshake
module fmap_stream_reader
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned K          = 6,
  parameter int unsigned OH         = 28,
  parameter int unsigned OW         = 28,
  parameter int unsigned RELU       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [0:K*OH*OW*DATA_WIDTH-1] fmap,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [clog2(K)-1:0]           out_channel,
  output logic [clog2(OH)-1:0]          out_row,
  output logic [clog2(OW)-1:0]          out_col,
  output logic                          out_last_ch,
  output logic                          out_last,
  output logic                          done
);

  localparam int unsigned TOTAL = K * OH * OW;
  localparam int unsigned EW    = clog2(TOTAL);

  fsm_state_t                   r_state;
  fsm_state_t                   w_state_next;
  logic                         w_capture;
  logic                         w_clear;
  logic                         w_advance;
  logic                         w_done_next;
  logic                         r_done;
  logic [0:TOTAL*DATA_WIDTH-1]  r_snap;
  logic [DATA_WIDTH-1:0]        w_elems [TOTAL];
  logic [EW-1:0]                w_elem_idx;
  logic [DATA_WIDTH-1:0]        w_elem;
  logic                         w_streaming;
  logic                         w_last_ch;
  logic                         w_last;

  // State and done pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // Frame snapshot; fmap is free to change once captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
    end else if (w_capture) begin
      r_snap <= fmap;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    w_advance    = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_clear      = 1'b1;
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          w_advance = 1'b1;
          if (w_last) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  fmap_index_counter #(
    .K  (K),
    .OH (OH),
    .OW (OW)
  ) u_index (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_advance   (w_advance),
    .o_channel   (out_channel),
    .o_row       (out_row),
    .o_col       (out_col),
    .o_last_ch_c (w_last_ch),
    .o_last_c    (w_last)
  );

  // Element mux: split the snapshot into elements, select by flat index
  for (genvar g = 0; g < TOTAL; g++) begin : g_elem
    assign w_elems[g] = r_snap[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_elem_idx = EW'(out_channel) * EW'(OH * OW)
                    + EW'(out_row) * EW'(OW)
                    + EW'(out_col);
  assign w_elem     = w_elems[w_elem_idx];

  // Optional ReLU: negative elements become zero, width unchanged
  if (RELU != 0) begin : g_relu
    assign out_data = w_elem[DATA_WIDTH-1] ? '0 : w_elem;
  end else begin : g_pass
    assign out_data = w_elem;
  end

  assign w_streaming = (r_state == ST_STREAM);
  assign busy        = w_streaming;
  assign out_valid   = w_streaming;
  assign out_last_ch = w_streaming & w_last_ch;
  assign out_last    = w_streaming & w_last;
  assign done        = r_done;

endmodule
